// File: rtl/window3x3_gen.sv
// 3x3 neighbourhood generator: raster pixel stream in, one zero-padded window per pixel out.
// Two line buffers plus a 3x3 tap array; the frame end is flushed with internal zero beats.
module window3x3_gen #(
  parameter int unsigned IMG_WIDTH  = 640,
  parameter int unsigned IMG_HEIGHT = 480,
  parameter int unsigned DATA_W     = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                inputDataValid,
  input  logic [DATA_W-1:0]   inputData,
  output logic                inputReady,
  output logic                outputDataValid,
  output logic [9*DATA_W-1:0] window,
  output logic                frameDone
);

  localparam int unsigned NumPix = IMG_WIDTH * IMG_HEIGHT;
  localparam int unsigned PixW   = $clog2(NumPix);
  localparam int unsigned PtrW   = $clog2(IMG_WIDTH);
  localparam int unsigned ColW   = $clog2(IMG_WIDTH + 1);
  localparam int unsigned RowW   = $clog2(IMG_HEIGHT);

  localparam logic [PixW-1:0] LastPix = PixW'(NumPix - 1);
  localparam logic [PixW-1:0] FillEnd = PixW'(IMG_WIDTH);
  localparam logic [PtrW-1:0] LastPtr = PtrW'(IMG_WIDTH - 1);
  localparam logic [ColW-1:0] LastCol = ColW'(IMG_WIDTH - 1);
  localparam logic [ColW-1:0] LastFlush = ColW'(IMG_WIDTH);
  localparam logic [RowW-1:0] LastRow = RowW'(IMG_HEIGHT - 1);

  typedef enum logic [1:0] {StFill, StRun, StFlush} state_e;

  state_e stateQ, stateD;
  logic [PixW-1:0] pixCntQ, pixCntD;
  logic [PtrW-1:0] ptrQ, ptrD;
  logic [ColW-1:0] flushCntQ, flushCntD;
  logic [ColW-1:0] colQ, colD;
  logic [RowW-1:0] rowQ, rowD;
  logic [2:0][2:0][DATA_W-1:0] tapQ, tapD;
  logic [9*DATA_W-1:0] windowQ, windowD, winMasked;
  logic validQ, validD, doneQ, doneD;

  logic [DATA_W-1:0] lineBuf0 [IMG_WIDTH];
  logic [DATA_W-1:0] lineBuf1 [IMG_WIDTH];

  logic beat, produce, kill;
  logic [DATA_W-1:0] pix;

  assign inputReady      = (stateQ != StFlush);
  assign beat            = (stateQ == StFlush) | (inputDataValid & inputReady);
  assign produce         = beat & (stateQ != StFill);
  assign pix             = (stateQ == StFlush) ? '0 : inputData;
  assign outputDataValid = validQ;
  assign window          = windowQ;
  assign frameDone       = doneQ;

  // Taps shift left one column per beat; the new right column is (k-2W, k-W, k).
  always_comb begin
    tapD = tapQ;
    if (beat) begin
      for (int i = 0; i < 3; i++) begin
        tapD[i][0] = tapQ[i][1];
        tapD[i][1] = tapQ[i][2];
      end
      tapD[0][2] = lineBuf0[ptrQ];
      tapD[1][2] = lineBuf1[ptrQ];
      tapD[2][2] = pix;
    end
  end

  // Border masking also hides line wrap and stale line-buffer contents.
  always_comb begin
    winMasked = '0;
    kill      = 1'b0;
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 3; j++) begin
        kill = (i == 0 && rowQ == '0) || (i == 2 && rowQ == LastRow) ||
               (j == 0 && colQ == '0) || (j == 2 && colQ == LastCol);
        winMasked[DATA_W*(3*i+j) +: DATA_W] = kill ? '0 : tapD[i][j];
      end
    end
  end

  always_comb begin
    stateD    = stateQ;
    pixCntD   = pixCntQ;
    ptrD      = ptrQ;
    flushCntD = flushCntQ;
    colD      = colQ;
    rowD      = rowQ;
    windowD   = windowQ;
    validD    = 1'b0;
    doneD     = 1'b0;
    if (beat) begin
      ptrD = (ptrQ == LastPtr) ? '0 : ptrQ + 1'b1;
      unique case (stateQ)
        StFill: begin
          pixCntD = pixCntQ + 1'b1;
          if (pixCntQ == FillEnd) stateD = StRun;
        end
        StRun: begin
          if (pixCntQ == LastPix) begin
            pixCntD   = '0;
            flushCntD = '0;
            stateD    = StFlush;
          end else begin
            pixCntD = pixCntQ + 1'b1;
          end
        end
        StFlush: begin
          flushCntD = flushCntQ + 1'b1;
          if (flushCntQ == LastFlush) begin
            stateD = StFill;
            doneD  = 1'b1;
          end
        end
        default: stateD = StFill;
      endcase
      if (produce) begin
        validD  = 1'b1;
        windowD = winMasked;
        if (colQ == LastCol) begin
          colD = '0;
          rowD = (rowQ == LastRow) ? '0 : rowQ + 1'b1;
        end else begin
          colD = colQ + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      stateQ    <= StFill;
      pixCntQ   <= '0;
      ptrQ      <= '0;
      flushCntQ <= '0;
      colQ      <= '0;
      rowQ      <= '0;
      tapQ      <= '0;
      windowQ   <= '0;
      validQ    <= 1'b0;
      doneQ     <= 1'b0;
    end else begin
      stateQ    <= stateD;
      pixCntQ   <= pixCntD;
      ptrQ      <= ptrD;
      flushCntQ <= flushCntD;
      colQ      <= colD;
      rowQ      <= rowD;
      tapQ      <= tapD;
      windowQ   <= windowD;
      validQ    <= validD;
      doneQ     <= doneD;
    end
  end

  // Line buffers are plain delay lines of IMG_WIDTH beats; never reset.
  always_ff @(posedge clk) begin
    if (beat) begin
      lineBuf1[ptrQ] <= pix;
      lineBuf0[ptrQ] <= lineBuf1[ptrQ];
    end
  end

endmodule

// File: tb/tb_window3x3_gen.sv
// Scoreboard bench for window3x3_gen on a 4x3 image: expected windows come from a hand table,
// a negedge monitor pops and compares every emitted window.
module tb_window3x3_gen;

  localparam int W = 4;
  localparam int H = 3;
  localparam int DW = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic inputDataValid = 1'b0;
  logic [DW-1:0] inputData = '0;
  logic inputReady, outputDataValid, frameDone;
  logic [9*DW-1:0] window;

  window3x3_gen #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .DATA_W(DW)) dut (
    .clk(clk),
    .rst(rst),
    .inputDataValid(inputDataValid),
    .inputData(inputData),
    .inputReady(inputReady),
    .outputDataValid(outputDataValid),
    .window(window),
    .frameDone(frameDone)
  );

  always #5 clk = ~clk;

  // Hand-computed windows for image values 1..12, slots s0..s8, one row per centre in raster order.
  int expTab [12][9] = '{
    '{0, 0, 0,  0, 1, 2,   0, 5, 6},
    '{0, 0, 0,  1, 2, 3,   5, 6, 7},
    '{0, 0, 0,  2, 3, 4,   6, 7, 8},
    '{0, 0, 0,  3, 4, 0,   7, 8, 0},
    '{0, 1, 2,  0, 5, 6,   0, 9, 10},
    '{1, 2, 3,  5, 6, 7,   9, 10, 11},
    '{2, 3, 4,  6, 7, 8,   10, 11, 12},
    '{3, 4, 0,  7, 8, 0,   11, 12, 0},
    '{0, 5, 6,  0, 9, 10,  0, 0, 0},
    '{5, 6, 7,  9, 10, 11, 0, 0, 0},
    '{6, 7, 8,  10, 11, 12, 0, 0, 0},
    '{7, 8, 0,  11, 12, 0, 0, 0, 0}
  };

  logic [9*DW:0] expQ [$];
  int total = 0;
  int bad = 0;
  int winCnt = 0;

  // Table values are image value (index+1); rebase to a frame whose first pixel is base.
  function automatic logic [9*DW:0] mkExp(int base, int n, bit last);
    logic [9*DW:0] e;
    int v;
    e = '0;
    for (int s = 0; s < 9; s++) begin
      v = expTab[n][s];
      e[DW*s +: DW] = (v == 0) ? 8'd0 : 8'(v - 1 + base);
    end
    e[9*DW] = last;
    return e;
  endfunction

  always @(negedge clk) begin
    logic [9*DW:0] e;
    if (outputDataValid) begin
      winCnt++;
      total++;
      if (expQ.size() == 0) begin
        bad++;
        $display("FAIL unexpected_window got=%h done=%0b expected none", window, frameDone);
      end else begin
        e = expQ.pop_front();
        if ({frameDone, window} !== e) begin
          bad++;
          $display("FAIL window got done=%0b win=%h expected done=%0b win=%h",
                   frameDone, window, e[9*DW], e[9*DW-1:0]);
        end
      end
    end else if (frameDone) begin
      total++;
      bad++;
      $display("FAIL frameDone_without_valid got=1 expected 0");
    end
  end

  task automatic check(string name, int got, int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s got=%0d expected=%0d", name, got, want);
    end
  endtask

  // Entry and exit at posedge+1.
  task automatic sendPixels(int base, int count, bit gaps);
    int idx = 0;
    int budget = 400;
    while (idx < count && budget > 0) begin
      inputDataValid = gaps ? ($urandom_range(0, 1) == 1) : 1'b1;
      inputData = 8'(base + idx);
      @(negedge clk);
      if (inputDataValid && inputReady) idx++;
      @(posedge clk);
      #1;
      budget--;
    end
    inputDataValid = 1'b0;
    if (idx < count) check("send_timeout", idx, count);
  endtask

  task automatic sendFrame(int base, bit gaps);
    for (int n = 0; n < W * H; n++) expQ.push_back(mkExp(base, n, n == W * H - 1));
    sendPixels(base, W * H, gaps);
  endtask

  task automatic drain(string name);
    int budget = 100;
    while (expQ.size() != 0 && budget > 0) begin
      @(posedge clk);
      #1;
      budget--;
    end
    repeat (3) @(posedge clk);
    #1;
    check(name, expQ.size(), 0);
  endtask

  initial begin
    int lowCnt;
    int base0;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_valid", int'(outputDataValid), 0);
    check("reset_done", int'(frameDone), 0);
    check("reset_window_zero", int'(window == '0), 1);
    check("reset_ready", int'(inputReady), 1);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Continuous frame; inputReady must drop for exactly W+1 cycles after the last pixel.
    base0 = winCnt;
    sendFrame(1, 1'b0);
    lowCnt = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (!inputReady) lowCnt++;
      else if (lowCnt > 0) break;
    end
    check("flush_ready_low_cycles", lowCnt, W + 1);
    drain("drain_frame1");
    check("frame1_windows", winCnt - base0, W * H);

    // Same data with random valid gaps.
    base0 = winCnt;
    sendFrame(1, 1'b1);
    drain("drain_gaps");
    check("gaps_windows", winCnt - base0, W * H);

    // Abandon a frame after 7 pixels: two windows are in flight, then reset.
    base0 = winCnt;
    expQ.push_back(mkExp(1, 0, 1'b0));
    expQ.push_back(mkExp(1, 1, 1'b0));
    sendPixels(1, 7, 1'b0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    check("valid_after_reset", int'(outputDataValid), 0);
    check("ready_after_reset", int'(inputReady), 1);
    check("partial_windows", winCnt - base0, 2);
    base0 = winCnt;
    sendFrame(1, 1'b0);
    drain("drain_after_reset");
    check("after_reset_windows", winCnt - base0, W * H);

    // Back-to-back frames; second frame is offered while the first is still flushing.
    base0 = winCnt;
    sendFrame(1, 1'b0);
    sendFrame(101, 1'b0);
    drain("drain_b2b");
    check("b2b_windows", winCnt - base0, 2 * W * H);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1);
  end

endmodule
